// File: rtl/awg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : awg_pkg
// Brief    : Shared waveform/field codes and control-word widths for the AWG
// Revision : 1.0 - initial release
// ============================================================================
package awg_pkg;

    localparam int FREQ_W  = 14;
    localparam int AMP_W   = 8;
    localparam int PHASE_W = 8;

    localparam logic [4:0] WAVE_SAW = 5'd0;
    localparam logic [4:0] WAVE_TRI = 5'd1;
    localparam logic [4:0] WAVE_SQR = 5'd2;
    localparam logic [4:0] WAVE_SIN = 5'd3;
    localparam logic [4:0] WAVE_OFF = 5'd10;

    localparam logic [1:0] FIELD_FREQ  = 2'd0;
    localparam logic [1:0] FIELD_AMP   = 2'd1;
    localparam logic [1:0] FIELD_PHASE = 2'd2;

    typedef enum logic [1:0] {
        KEY_MODE = 2'd0,
        KEY_SEL  = 2'd1,
        KEY_UP   = 2'd2,
        KEY_DOWN = 2'd3
    } key_idx_e;

    function automatic logic [4:0] next_wave(input logic [4:0] cur);
        logic [4:0] nxt;
        case (cur)
            WAVE_SAW: nxt = WAVE_TRI;
            WAVE_TRI: nxt = WAVE_SQR;
            WAVE_SQR: nxt = WAVE_SIN;
            WAVE_SIN: nxt = WAVE_OFF;
            default:  nxt = WAVE_SAW;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] next_field(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            FIELD_FREQ: nxt = FIELD_AMP;
            FIELD_AMP:  nxt = FIELD_PHASE;
            default:    nxt = FIELD_FREQ;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop synchronizer, counter debouncer and one-cycle press pulse
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_vld1;
    logic               r_vld2;
    logic               r_armed;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // r_armed only sets once a genuine released sample has come through the
    // synchronizer, so a key held across reset cannot produce a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_vld1    <= 1'b0;
            r_vld2    <= 1'b0;
            r_armed   <= 1'b0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_vld1    <= 1'b1;
            r_vld2    <= r_vld1;
            if (r_vld2 && r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            r_level_d <= r_level;
            r_press   <= r_armed & r_level_d & ~r_level;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/awg_param_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : awg_param_ctrl
// Brief    : Front-panel key handling, waveform/field FSMs and parameter edits
// Revision : 1.0 - initial release
// ============================================================================
module awg_param_ctrl
    import awg_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter logic [FREQ_W-1:0]  FREQ_STEP       = 14'd16,
    parameter logic [FREQ_W-1:0]  FREQ_MIN        = 14'd1,
    parameter logic [FREQ_W-1:0]  FREQ_MAX        = 14'd16383,
    parameter logic [AMP_W-1:0]   AMP_STEP        = 8'd8,
    parameter logic [PHASE_W-1:0] PHASE_STEP      = 8'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_mode_n,
    input  logic               key_sel_n,
    input  logic               key_up_n,
    input  logic               key_down_n,
    output logic [4:0]         state,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase,
    output logic [1:0]         sel_field
);

    logic [3:0] w_keys_n;
    logic [3:0] w_level;
    logic [3:0] w_press;
    logic [3:0] w_pulse;

    assign w_keys_n = {key_down_n, key_up_n, key_sel_n, key_mode_n};

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (w_keys_n[gi]),
            .level (w_level[gi]),
            .press (w_press[gi])
        );
    end

    // A press only counts while the debounced key is still down.
    assign w_pulse = w_press & ~w_level;

    logic                     w_up;
    logic                     w_dn;
    logic [FREQ_W:0]          w_freq_sum;
    logic signed [FREQ_W+1:0] w_freq_diff;
    logic [FREQ_W-1:0]        w_freq_up;
    logic [FREQ_W-1:0]        w_freq_dn;
    logic [AMP_W:0]           w_amp_sum;
    logic [AMP_W-1:0]         w_amp_up;
    logic [AMP_W-1:0]         w_amp_dn;

    logic [4:0]               r_state;
    logic [FREQ_W-1:0]        r_freq;
    logic [AMP_W-1:0]         r_amp;
    logic [PHASE_W-1:0]       r_phase;
    logic [1:0]               r_sel;

    assign w_up = w_pulse[KEY_UP] & ~w_pulse[KEY_DOWN];
    assign w_dn = w_pulse[KEY_DOWN] & ~w_pulse[KEY_UP];

    always_comb begin
        w_freq_sum  = {1'b0, r_freq} + {1'b0, FREQ_STEP};
        w_freq_diff = $signed({2'b00, r_freq}) - $signed({2'b00, FREQ_STEP});
        w_freq_up   = (w_freq_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_freq_sum[FREQ_W-1:0];
        w_freq_dn   = (w_freq_diff < $signed({2'b00, FREQ_MIN})) ? FREQ_MIN
                                                                 : w_freq_diff[FREQ_W-1:0];
        w_amp_sum   = {1'b0, r_amp} + {1'b0, AMP_STEP};
        w_amp_up    = w_amp_sum[AMP_W] ? {AMP_W{1'b1}} : w_amp_sum[AMP_W-1:0];
        w_amp_dn    = (r_amp < AMP_STEP) ? '0 : r_amp - AMP_STEP;
    end

    // Edits use the field selected before a coincident sel press takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAVE_SAW;
            r_freq  <= FREQ_MIN;
            r_amp   <= {AMP_W{1'b1}};
            r_phase <= '0;
            r_sel   <= FIELD_FREQ;
        end else begin
            if (w_pulse[KEY_MODE]) begin
                r_state <= next_wave(r_state);
            end
            if (w_pulse[KEY_SEL]) begin
                r_sel <= next_field(r_sel);
            end
            if (w_up) begin
                case (r_sel)
                    FIELD_FREQ:  r_freq  <= w_freq_up;
                    FIELD_AMP:   r_amp   <= w_amp_up;
                    FIELD_PHASE: r_phase <= r_phase + PHASE_STEP;
                    default: ;
                endcase
            end else if (w_dn) begin
                case (r_sel)
                    FIELD_FREQ:  r_freq  <= w_freq_dn;
                    FIELD_AMP:   r_amp   <= w_amp_dn;
                    FIELD_PHASE: r_phase <= r_phase - PHASE_STEP;
                    default: ;
                endcase
            end
        end
    end

    assign state       = r_state;
    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign sel_field   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_awg_param_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_awg_param_ctrl
// Brief    : Self-checking bench for awg_param_ctrl against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_awg_param_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_mode_n = 1'b1;
    logic        key_sel_n = 1'b1;
    logic        key_up_n = 1'b1;
    logic        key_down_n = 1'b1;
    logic [4:0]  state;
    logic [13:0] state_freq;
    logic [7:0]  state_amp;
    logic [7:0]  state_phase;
    logic [1:0]  sel_field;

    awg_param_ctrl #(
        .DEBOUNCE_CYCLES(DEB)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_sel_n   (key_sel_n),
        .key_up_n    (key_up_n),
        .key_down_n  (key_down_n),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .sel_field   (sel_field)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_state, m_freq, m_amp, m_phase, m_sel;
    int waves[5] = '{0, 1, 2, 3, 10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".state"}, 32'(state),       m_state);
        check({where, ".freq"},  32'(state_freq),  m_freq);
        check({where, ".amp"},   32'(state_amp),   m_amp);
        check({where, ".phase"}, 32'(state_phase), m_phase);
        check({where, ".sel"},   32'(sel_field),   m_sel);
    endtask

    function automatic void model_reset();
        m_state = 0; m_freq = 1; m_amp = 255; m_phase = 0; m_sel = 0;
    endfunction

    // mask bits: 0 mode, 1 sel, 2 up, 3 down
    function automatic void model_apply(input logic [3:0] m);
        if (m[0]) begin
            int idx = 0;
            for (int i = 0; i < 5; i++) if (waves[i] == m_state) idx = i;
            m_state = waves[(idx + 1) % 5];
        end
        if (m[2] && !m[3]) begin
            case (m_sel)
                0: m_freq  = (m_freq + 16 > 16383) ? 16383 : m_freq + 16;
                1: m_amp   = (m_amp + 8 > 255) ? 255 : m_amp + 8;
                default: m_phase = (m_phase + 4) % 256;
            endcase
        end else if (m[3] && !m[2]) begin
            case (m_sel)
                0: m_freq  = (m_freq - 16 < 1) ? 1 : m_freq - 16;
                1: m_amp   = (m_amp - 8 < 0) ? 0 : m_amp - 8;
                default: m_phase = (m_phase - 4 + 256) % 256;
            endcase
        end
        if (m[1]) m_sel = (m_sel + 1) % 3;
    endfunction

    task automatic drive_keys(input logic [3:0] m);
        key_mode_n = ~m[0];
        key_sel_n  = ~m[1];
        key_up_n   = ~m[2];
        key_down_n = ~m[3];
    endtask

    task automatic do_press(input logic [3:0] m, input int hold);
        drive_keys(m);
        repeat (hold) @(negedge clk);
        drive_keys(4'b0000);
        repeat (12) @(negedge clk);
        model_apply(m);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int changes;
        logic [4:0] prev;

        repeat (3) @(negedge clk);
        model_reset();
        check_all("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // press latency and single update on a long hold
        key_mode_n = 1'b0;
        @(posedge clk);
        lat = -1;
        changes = 0;
        prev = state;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (state !== prev) begin
                changes++;
                if (lat < 0) lat = k;
                prev = state;
            end
        end
        @(negedge clk);
        key_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check("press_latency", 32'(lat), 32'(2 + DEB + 1));
        check("hold_updates", 32'(changes), 32'd1);
        model_apply(4'b0001);
        check_all("hold20");

        // short glitch must not register
        key_mode_n = 1'b0;
        repeat (2) @(negedge clk);
        key_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("glitch");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_press(4'b0001, 10);
            check("mode_seq", 32'(state), m_state);
        end
        check("mode_wrap", 32'(state), 32'd0);

        // frequency upper saturation
        do_reset();
        for (int i = 0; i < 1023; i++) do_press(4'b0100, 6);
        check_all("freq_16369");
        do_press(4'b0100, 6);
        check("freq_sat", 32'(state_freq), 32'd16383);
        do_press(4'b0100, 6);
        check("freq_sat_hold", 32'(state_freq), 32'd16383);

        // frequency lower saturation
        do_reset();
        do_press(4'b0100, 8);
        check("freq_17", 32'(state_freq), 32'd17);
        do_press(4'b1000, 8);
        check("freq_min", 32'(state_freq), 32'd1);
        do_press(4'b1000, 8);
        check("freq_min_hold", 32'(state_freq), 32'd1);

        // amplitude saturation both ways
        do_press(4'b0010, 8);
        check("sel_amp", 32'(sel_field), 32'd1);
        do_press(4'b0100, 8);
        check("amp_top", 32'(state_amp), 32'd255);
        for (int i = 0; i < 32; i++) do_press(4'b1000, 6);
        check("amp_zero", 32'(state_amp), 32'd0);
        do_press(4'b1000, 6);
        check("amp_zero_hold", 32'(state_amp), 32'd0);
        check_all("amp_done");

        // phase wraps modulo 256
        do_press(4'b0010, 8);
        do_press(4'b1000, 8);
        check("phase_252", 32'(state_phase), 32'd252);
        do_press(4'b0100, 8);
        do_press(4'b0100, 8);
        check("phase_4", 32'(state_phase), 32'd4);

        // coincident presses
        do_press(4'b1100, 8);
        check_all("updown_phase");
        do_press(4'b0010, 8);
        do_press(4'b1100, 8);
        check("updown_freq", 32'(state_freq), 32'd1);
        do_press(4'b0110, 8);
        check("selup_freq", 32'(state_freq), 32'd17);
        check("selup_sel", 32'(sel_field), 32'd1);
        check("selup_amp", 32'(state_amp), 32'd0);
        do_press(4'b0101, 8);
        check_all("mode_up");

        // async reset while a press is mid-debounce
        key_up_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_all("held_through_rst");
        key_up_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("released_after_rst");
        do_press(4'b0100, 8);
        check("fresh_press", 32'(state_freq), 32'd17);

        // randomized key combinations
        for (int i = 0; i < 150; i++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            do_press(m, $urandom_range(6, 12));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/awg_param_ctrl.md
Name: awg_param_ctrl

Overview:
Front-panel control stage sitting directly upstream of the waveform generator; it produces the waveform select and the frequency/amplitude/phase control words the generator consumes. It debounces four raw push-buttons, edge-detects presses, and runs a field-select FSM. Up/down presses edit the selected parameter with saturating or wrapping arithmetic. All outputs are registered and held stable between presses.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive equal synchronized samples required to accept a key level change (10 ms at 50 MHz)
FREQ_STEP, 14'd16, increment/decrement applied to state_freq per press
FREQ_MIN, 14'd1, lower saturation bound of state_freq
FREQ_MAX, 14'd16383, upper saturation bound of state_freq
AMP_STEP, 8'd8, increment/decrement applied to state_amp per press
PHASE_STEP, 8'd4, increment/decrement applied to state_phase per press (modulo 256)

Ports:
clk  input  1  system clock, also the DAC clock domain
rst_n  input  1  asynchronous active-low reset
key_mode_n  input  1  raw button, active low: cycle waveform
key_sel_n  input  1  raw button, active low: cycle edited field
key_up_n  input  1  raw button, active low: increase selected field
key_down_n  input  1  raw button, active low: decrease selected field
state  output  5  waveform select: 0 saw, 1 triangle, 2 square, 3 sine, 10 off
state_freq  output  14  frequency control word
state_amp  output  8  amplitude control word
state_phase  output  8  phase offset control word
sel_field  output  2  field being edited: 0 freq, 1 amp, 2 phase (3 never driven)

Behaviour:
- Reset (rst_n low, async): state=0, state_freq=FREQ_MIN, state_amp=8'd255, state_phase=0, sel_field=0; debounced levels=1 (released), debounce counters=0, synchronizer flops=1. Reset asserted mid-debounce or mid-press discards the press; no pulse after release of reset until a fresh release->press sequence.
- Per key: 2-flop synchronizer, then debounce counter. Counter clears whenever the synchronized sample equals the current debounced level; otherwise increments; on reaching DEBOUNCE_CYCLES-1 the debounced level toggles and the counter clears. Glitch shorter than DEBOUNCE_CYCLES synchronized samples: no level change.
- Press pulse: one clk wide, asserted the cycle after the debounced level goes 1->0. Release generates no pulse. Held key: exactly one pulse (no auto-repeat).
- Register update on the clk edge at the end of the pulse cycle; outputs are registered (no combinational path from keys).
- Mode pulse: state 0->1->2->3->10->0. Any other state value (unreachable) goes to 0.
- Sel FSM states F_FREQ(0)->F_AMP(1)->F_PHASE(2)->F_FREQ on each sel pulse.
- Up pulse: freq = min(freq+FREQ_STEP, FREQ_MAX), computed 15 bits wide, no wrap; amp = min(amp+AMP_STEP, 255), 9-bit compute; phase = (phase+PHASE_STEP) mod 256.
- Down pulse: freq = max(freq-FREQ_STEP, FREQ_MIN), signed/extended compute, never underflows; amp = max(amp-AMP_STEP, 0); phase = (phase-PHASE_STEP) mod 256.
- Simultaneous up and down pulses in the same cycle: both ignored, no change.
- Sel pulse coincident with up/down: edit applies to the field selected before the sel change; sel_field advances the same edge.
- Mode pulse is independent of field editing; coincident mode and up/down both take effect.
- Editing is permitted in every state including 10 (off).

Decomposition:
- Shared package awg_pkg: waveform codes WAVE_SAW=5'd0, WAVE_TRI=5'd1, WAVE_SQR=5'd2, WAVE_SIN=5'd3, WAVE_OFF=5'd10; field codes FIELD_FREQ/AMP/PHASE; control-word widths FREQ_W=14, AMP_W=8, PHASE_W=8 (shared with the generator's inputs).
- One sub-module: key_debounce (synchronizer + counter + falling-edge pulse, parameter DEBOUNCE_CYCLES, ports clk, rst_n, key_n, level, press), instantiated four times. Top holds the FSM and arithmetic.

Test Plan:
- DEBOUNCE_CYCLES=4; reset pulse -> state=0, freq=1, amp=255, phase=0, sel_field=0; hold key_mode_n low 20 cycles -> exactly one update, state=1, press pulse 2 sync + 4 debounce + 1 cycles after first low sample.
- Key_mode low for 2 cycles then high (glitch) -> no change; five clean mode presses from reset -> state sequence 1,2,3,10,0.
- sel_field=0, freq=16370, one up press -> 16383; another up -> stays 16383; from freq=10 one down -> 1 (FREQ_MIN).
- Select amp (one sel press), amp=255, up -> 255; 32 down presses -> 0, then down -> 0; select phase, phase=0, down -> 252, up twice -> 4.
- Up and down keys pressed on the same sample edge -> pulses coincide, freq unchanged; sel and up on same edge with sel_field=0 -> freq+16, sel_field=1, amp unchanged.
- rst_n low for 1 cycle while key_up_n held low mid-debounce -> all outputs at reset values immediately (async), no update after rst_n rises while key stays held; release then press -> single update.
